muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO and raises a pipeline stall.
// Optional feature: define MULDIV_SIGNED_EN to enable signed MULT/DIV (op[1]); otherwise all ops are unsigned.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic                 div_q, div_d, bz_q, bz_d, done_q, done_d;
  logic                 launch;
  logic [WIDTH-1:0]     abs_a, abs_b, quo, rem;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       mul_sum, div_sh, div_diff;
  assign launch = (state_q == IDLE) && start && !flush;
`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_d, rneg_q, rneg_d;
  assign a_neg = op[1] & srcA[WIDTH-1];
  assign b_neg = op[1] & srcB[WIDTH-1];
  assign abs_a = a_neg ? -srcA : srcA;
  assign abs_b = b_neg ? -srcB : srcB;
  always_comb begin
    neg_d  = launch ? a_neg ^ b_neg : neg_q;
    rneg_d = launch ? a_neg : rneg_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
    end
  end
  // Remainder follows the dividend's sign; product and quotient follow the XOR of signs.
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
  logic unused_op;
  assign unused_op = op[1];
  assign abs_a = srcA;
  assign abs_b = srcB;
  assign prod  = acc_q;
  assign quo   = acc_q[WIDTH-1:0];
  assign rem   = acc_q[2*WIDTH-1:WIDTH];
`endif
  // acc holds {upper product, multiplier} for mul and {remainder, quotient} for div.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, b_q};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    bz_d    = bz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hilo_we[1]) hi_d = hilo_wdata;
        if (hilo_we[0]) lo_d = hilo_wdata;
        if (launch) begin
          state_d = CALC;
          cnt_d   = CNT_W'(WIDTH);
          acc_d   = {{WIDTH{1'b0}}, abs_a};
          a_d     = srcA;
          b_d     = abs_b;
          div_d   = op[0];
          bz_d    = (srcB == '0);
        end
      end
      CALC: begin
        acc_d   = div_q ? {div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], ~div_diff[WIDTH]}
                        : {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = flush ? IDLE : (cnt_q == CNT_W'(1)) ? FIX : CALC;
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d   = !div_q ? prod[2*WIDTH-1:WIDTH] : bz_q ? a_q : rem;
          lo_d   = !div_q ? prod[WIDTH-1:0] : bz_q ? '1 : quo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign stall = busy & (start | hilo_rd | (|hilo_we));
endmodule
